// File: rtl/pbit_activation_node.sv
// pbit_activation_node: serially sums signed activation terms into a saturating field and emits a stochastic spin
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   act_in     4-bit signed activation term
//   act_valid  act_in beat valid
//   act_last   final term of the current update (qualified by act_valid)
//   act_ready  node can accept a term (ACCUM state)
//   m_out      spin, 1 = +1, 0 = -1
//   m_valid    m_out holds a fresh update
//   m_ready    consumer accepts m_out
//   field_out  saturated field of the last update
//   clamp_en   (PBIT_CLAMP_EN only) force the next spin to clamp_val
//   clamp_val  (PBIT_CLAMP_EN only) forced spin value
//
// Build option: define PBIT_CLAMP_EN to add the clamp_en/clamp_val ports.
module pbit_activation_node #(
  parameter int          ACC_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       act_in,
  input  logic             act_valid,
  input  logic             act_last,
  output logic             act_ready,
  output logic             m_out,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef PBIT_CLAMP_EN
  input  logic             clamp_en,
  input  logic             clamp_val,
`endif
  output logic [ACC_W-1:0] field_out
);
  typedef enum logic [1:0] {ACCUM, SAMPLE, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t                  r_state, w_next;
  logic signed [ACC_W-1:0] r_acc, r_field, w_acc_sat;
  logic        [ACC_W:0]   w_sum;
  logic        [15:0]      r_lfsr;
  logic                    w_cmp, w_m;
  // One guard bit: the two top bits disagree exactly when the add overflowed.
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-3){act_in[3]}}, act_in};
  assign w_acc_sat = (w_sum[ACC_W] != w_sum[ACC_W-1]) ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                      : w_sum[ACC_W-1:0];
  assign w_cmp     = r_acc >= $signed(r_lfsr[ACC_W-1:0]);
`ifdef PBIT_CLAMP_EN
  assign w_m = clamp_en ? clamp_val : w_cmp;
`else
  assign w_m = w_cmp;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == ACCUM && act_valid && act_last) ? SAMPLE :
             (r_state == SAMPLE)                          ? HOLD   :
             (r_state == HOLD && m_valid && m_ready)      ? ACCUM  : r_state;
  end
  always_comb begin
    act_ready = (r_state == ACCUM);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_SEED;
      r_acc   <= '0;
      r_field <= '0;
      m_out   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (r_state == ACCUM && act_valid) r_acc <= w_acc_sat;
      if (r_state == SAMPLE) begin
        m_out   <= w_m;
        r_field <= r_acc;
        m_valid <= 1'b1;
        r_acc   <= '0;
      end
      if (r_state == HOLD && m_valid && m_ready) m_valid <= 1'b0;
    end
  end
  assign field_out = r_field;
endmodule
